mix_key_round: RTL and testbench

//  AES-128 round back-end; sits directly downstream of the row-shift stage.

---
 rtl/aes_pkg.sv | 41 ++++
 rtl/aes_sbox.sv | 11 +
 rtl/mix_key_round.sv | 137 +++++++++++++
 tb/tb_mix_key_round.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES helpers: byte geometry, GF(2^8) doubling/tripling and the forward S-box.
package aes_pkg;

    localparam int BYTE_W = 8;
    localparam int NB     = 4;

    localparam logic [7:0] LAST_RCON_DEF = 8'h36;
    localparam logic [7:0] RCON_POLY_DEF = 8'h1B;

    function automatic logic [7:0] xtime(input logic [7:0] b, input logic [7:0] poly);
        return {b[6:0], 1'b0} ^ (b[7] ? poly : 8'h00);
    endfunction

    function automatic logic [7:0] gmul2(input logic [7:0] b, input logic [7:0] poly);
        return xtime(b, poly);
    endfunction

    function automatic logic [7:0] gmul3(input logic [7:0] b, input logic [7:0] poly);
        return xtime(b, poly) ^ b;
    endfunction

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

endpackage

// File: rtl/aes_sbox.sv
// Single-byte forward S-box lookup, purely combinational; shared with the SubBytes stage.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_byte_i,
    output logic [7:0] out_byte_o
);

    assign out_byte_o = SBOX[in_byte_i];

endmodule

// File: rtl/mix_key_round.sv
// AES-128 round back-end: MixColumns + next-key expansion in stage 1, AddRoundKey in stage 2,
// with empty/ready flow control and no skid buffer.
module mix_key_round
    import aes_pkg::*;
#(
    parameter logic [7:0] LAST_RCON = LAST_RCON_DEF,
    parameter logic [7:0] RCON_POLY = RCON_POLY_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] state_in,
    input  logic [127:0] key_in,
    input  logic [7:0]   rcon_in,
    input  logic         in_empty,
    output logic         in_ready,
    output logic [127:0] state_out,
    output logic [127:0] key_out,
    output logic [7:0]   rcon_out,
    output logic         out_empty,
    input  logic         out_ready
);

    logic         s1_valid_q;
    logic         s2_valid_q;
    logic         s1_en;
    logic         s2_en;
    logic         in_fire;
    logic         last_round;

    logic [127:0] mix_d;
    logic [127:0] s1_state_d;
    logic [127:0] next_key_d;
    logic [7:0]   s1_rcon_d;

    logic [127:0] s1_state_q;
    logic [127:0] s1_key_q;
    logic [7:0]   s1_rcon_q;
    logic [127:0] s2_state_q;
    logic [127:0] s2_key_q;
    logic [7:0]   s2_rcon_q;

    logic [7:0]   rot_w  [NB];
    logic [7:0]   sub_w  [NB];
    logic [7:0]   temp_w [NB];

    assign s2_en    = !s2_valid_q || out_ready;
    assign s1_en    = !s1_valid_q || s2_en;
    assign in_ready = s1_en;
    assign in_fire  = !in_empty && s1_en;

    // Byte (row r, col c) lives at [127 - 8*(4r+c) -: 8]; each column mixes rows r..r+3 cyclically.
    for (genvar gi = 0; gi < NB; gi++) begin : g_col
        for (genvar gr = 0; gr < NB; gr++) begin : g_row
            localparam int P0 = 127 - BYTE_W * (NB * gr + gi);
            localparam int P1 = 127 - BYTE_W * (NB * ((gr + 1) % NB) + gi);
            localparam int P2 = 127 - BYTE_W * (NB * ((gr + 2) % NB) + gi);
            localparam int P3 = 127 - BYTE_W * (NB * ((gr + 3) % NB) + gi);
            assign mix_d[P0 -: BYTE_W] = gmul2(state_in[P0 -: BYTE_W], RCON_POLY)
                                       ^ gmul3(state_in[P1 -: BYTE_W], RCON_POLY)
                                       ^ state_in[P2 -: BYTE_W]
                                       ^ state_in[P3 -: BYTE_W];
        end
    end

    // RotWord of column 3 feeds SubWord; Rcon only touches row 0.
    for (genvar gi = 0; gi < NB; gi++) begin : g_subword
        localparam int ROT_MSB = 127 - BYTE_W * (NB * ((gi + 1) % NB) + (NB - 1));
        assign rot_w[gi] = key_in[ROT_MSB -: BYTE_W];

        aes_sbox u_sbox (
            .in_byte_i  (rot_w[gi]),
            .out_byte_o (sub_w[gi])
        );

        if (gi == 0) begin : g_rcon
            assign temp_w[gi] = sub_w[gi] ^ rcon_in;
        end else begin : g_plain
            assign temp_w[gi] = sub_w[gi];
        end
    end

    // w_c' = temp ^ w0 ^ ... ^ w_c, flattened so no word depends on another's output.
    always_comb begin
        logic [7:0] acc;
        next_key_d = '0;
        acc        = '0;
        for (int r = 0; r < NB; r++) begin
            acc = temp_w[r];
            for (int c = 0; c < NB; c++) begin
                acc = acc ^ key_in[127 - BYTE_W * (NB * r + c) -: BYTE_W];
                next_key_d[127 - BYTE_W * (NB * r + c) -: BYTE_W] = acc;
            end
        end
    end

    assign last_round = (rcon_in == LAST_RCON);
    assign s1_state_d = last_round ? state_in : mix_d;
    assign s1_rcon_d  = xtime(rcon_in, RCON_POLY);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_state_q <= '0;
            s1_key_q   <= '0;
            s1_rcon_q  <= '0;
        end else if (s1_en) begin
            s1_valid_q <= in_fire;
            if (in_fire) begin
                s1_state_q <= s1_state_d;
                s1_key_q   <= next_key_d;
                s1_rcon_q  <= s1_rcon_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_state_q <= '0;
            s2_key_q   <= '0;
            s2_rcon_q  <= '0;
        end else if (s2_en) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_state_q <= s1_state_q ^ s1_key_q;
                s2_key_q   <= s1_key_q;
                s2_rcon_q  <= s1_rcon_q;
            end
        end
    end

    assign state_out = s2_state_q;
    assign key_out   = s2_key_q;
    assign rcon_out  = s2_rcon_q;
    assign out_empty = !s2_valid_q;

endmodule

// File: tb/tb_mix_key_round.sv
// Scoreboard bench for mix_key_round: FIPS-197 vectors plus an independently derived AES round model.
module tb_mix_key_round;

    typedef struct packed {
        logic [127:0] st;
        logic [127:0] key;
        logic [7:0]   rcon;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] state_in;
    logic [127:0] key_in;
    logic [7:0]   rcon_in;
    logic         in_empty;
    logic         in_ready;
    logic [127:0] state_out;
    logic [127:0] key_out;
    logic [7:0]   rcon_out;
    logic         out_empty;
    logic         out_ready;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          n_out  = 0;
    logic [7:0]  sbox_m [256];

    always #5 clk = ~clk;

    mix_key_round dut (
        .clk       (clk),
        .rst       (rst),
        .state_in  (state_in),
        .key_in    (key_in),
        .rcon_in   (rcon_in),
        .in_empty  (in_empty),
        .in_ready  (in_ready),
        .state_out (state_out),
        .key_out   (key_out),
        .rcon_out  (rcon_out),
        .out_empty (out_empty),
        .out_ready (out_ready)
    );

    // ---------------- reference model ----------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from first principles: multiplicative inverse followed by the affine map.
    function automatic void build_sbox();
        logic [7:0] inv;
        logic [7:0] xb;
        for (int x = 0; x < 256; x++) begin
            xb  = 8'(x);
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gf_mul(xb, 8'(y)) == 8'h01) inv = 8'(y);
            sbox_m[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                      ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endfunction

    function automatic logic [7:0] gb(input logic [127:0] v, input int i);
        return v[127 - 8*i -: 8];
    endfunction

    // FIPS vectors are column-major; the block uses row-major.
    function automatic logic [127:0] transpose(input logic [127:0] v);
        logic [127:0] o;
        o = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[127 - 8*(4*r + c) -: 8] = gb(v, 4*c + r);
        return o;
    endfunction

    function automatic logic [127:0] model_mix(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127 - 8*(4*r + c) -: 8] = gf_mul(gb(s, 4*r + c), 8'h02)
                                          ^ gf_mul(gb(s, 4*((r+1)%4) + c), 8'h03)
                                          ^ gb(s, 4*((r+2)%4) + c)
                                          ^ gb(s, 4*((r+3)%4) + c);
        return o;
    endfunction

    function automatic logic [127:0] model_key(input logic [127:0] k, input logic [7:0] rc);
        logic [127:0] nk;
        logic [7:0]   t;
        nk = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                if (c == 0) t = sbox_m[gb(k, 4*((r+1)%4) + 3)] ^ ((r == 0) ? rc : 8'h00);
                else        t = gb(nk, 4*r + c - 1);
                nk[127 - 8*(4*r + c) -: 8] = gb(k, 4*r + c) ^ t;
            end
        return nk;
    endfunction

    function automatic exp_t model(input logic [127:0] s, input logic [127:0] k, input logic [7:0] rc);
        exp_t e;
        e.key  = model_key(k, rc);
        e.st   = ((rc == 8'h36) ? s : model_mix(s)) ^ e.key;
        e.rcon = gf_mul(rc, 8'h02);
        return e;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- output monitor ----------------
    always @(negedge clk) begin
        if (!rst && !out_empty && out_ready) begin
            n_out++;
            $display("OUT %0d state=%h key=%h rcon=%h", n_out, state_out, key_out, rcon_out);
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_output state_out=%h (no block outstanding)", state_out);
            end else begin
                mon_e = sb.pop_front();
                checks++;
                if (state_out !== mon_e.st) begin
                    errors++;
                    $display("FAIL state_out got %h expected %h", state_out, mon_e.st);
                end
                checks++;
                if (key_out !== mon_e.key) begin
                    errors++;
                    $display("FAIL key_out got %h expected %h", key_out, mon_e.key);
                end
                checks++;
                if (rcon_out !== mon_e.rcon) begin
                    errors++;
                    $display("FAIL rcon_out got %h expected %h", rcon_out, mon_e.rcon);
                end
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic send(input logic [127:0] s, input logic [127:0] k, input logic [7:0] r, input exp_t e);
        int waited;
        waited   = 0;
        state_in = s;
        key_in   = k;
        rcon_in  = r;
        in_empty = 1'b0;
        @(negedge clk);
        while (!in_ready && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout in_ready=%b expected 1 within 20 cycles", in_ready);
        end else begin
            sb.push_back(e);
        end
        @(posedge clk); #1;
        in_empty = 1'b1;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain outstanding=%0d expected 0", sb.size());
        end
        @(posedge clk); #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst       = 1'b1;
        out_ready = 1'b1;
        in_empty  = 1'b0;
        state_in  = rand128();
        key_in    = rand128();
        rcon_in   = 8'h01;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (out_empty !== 1'b1)  begin errors++; $display("FAIL reset_out_empty got %b expected 1", out_empty); end
        checks++; if (in_ready !== 1'b1)   begin errors++; $display("FAIL reset_in_ready got %b expected 1", in_ready); end
        checks++; if (state_out !== '0)    begin errors++; $display("FAIL reset_state_out got %h expected 0", state_out); end
        checks++; if (key_out !== '0)      begin errors++; $display("FAIL reset_key_out got %h expected 0", key_out); end
        checks++; if (rcon_out !== 8'h00)  begin errors++; $display("FAIL reset_rcon_out got %h expected 00", rcon_out); end
        @(posedge clk); #1;
        in_empty = 1'b1;
        rst      = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (out_empty !== 1'b1)  begin errors++; $display("FAIL post_reset_idle out_empty got %b expected 1", out_empty); end
        @(posedge clk); #1;
    endtask

    task automatic test_round1();
        exp_t e;
        e.st   = transpose(128'ha49c7ff2689f352b6b5bea43026a5049);
        e.key  = transpose(128'ha0fafe1788542cb123a339392a6c7605);
        e.rcon = 8'h02;
        send(transpose(128'hd4bf5d30e0b452aeb84111f11e2798e5),
             transpose(128'h2b7e151628aed2a6abf7158809cf4f3c), 8'h01, e);
        @(negedge clk);
        checks++; if (out_empty !== 1'b1) begin errors++; $display("FAIL latency_early out_empty got %b expected 1", out_empty); end
        @(negedge clk);
        checks++; if (out_empty !== 1'b0) begin errors++; $display("FAIL latency_2 out_empty got %b expected 0", out_empty); end
        wait_drain();
    endtask

    task automatic test_last_round();
        exp_t e;
        e.st   = transpose(128'h3925841d02dc09fbdc118597196a0b32);
        e.key  = transpose(128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        e.rcon = 8'h6c;
        send(transpose(128'he9317db5cb322c723d2e895faf090794),
             transpose(128'hac7766f319fadc2128d12941575c006e), 8'h36, e);
        wait_drain();
    endtask

    task automatic test_rcon_wrap();
        exp_t e;
        logic [127:0] s;
        logic [127:0] k;
        s = rand128(); k = rand128();
        e = model(s, k, 8'h80); e.rcon = 8'h1B;
        send(s, k, 8'h80, e);
        s = rand128(); k = rand128();
        e = model(s, k, 8'h1B); e.rcon = 8'h36;
        send(s, k, 8'h1B, e);
        wait_drain();
    endtask

    task automatic test_back_to_back();
        logic [7:0]   rc_tab [8];
        logic [127:0] s;
        logic [127:0] k;
        time          t0;
        rc_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'hA5};
        t0 = $time;
        for (int i = 0; i < 8; i++) begin
            s = rand128(); k = rand128();
            send(s, k, rc_tab[i], model(s, k, rc_tab[i]));
        end
        checks++;
        if (($time - t0) != 80) begin
            errors++;
            $display("FAIL back_to_back_throughput took %0t expected 80 (8 cycles)", $time - t0);
        end
        wait_drain();
    endtask

    task automatic test_backpressure();
        logic [127:0] s [4];
        logic [127:0] k [4];
        logic [7:0]   rc [4];
        exp_t         e [4];
        for (int i = 0; i < 4; i++) begin
            s[i] = rand128(); k[i] = rand128(); rc[i] = 8'(i + 1);
            e[i] = model(s[i], k[i], rc[i]);
        end
        out_ready = 1'b0;
        send(s[0], k[0], rc[0], e[0]);
        send(s[1], k[1], rc[1], e[1]);
        state_in = s[2]; key_in = k[2]; rcon_in = rc[2]; in_empty = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready cyc %0d got %b expected 0", c, in_ready); end
            checks++; if (out_empty !== 1'b0) begin errors++; $display("FAIL stall_out_empty cyc %0d got %b expected 0", c, out_empty); end
            checks++; if (state_out !== e[0].st) begin errors++; $display("FAIL stall_hold cyc %0d state_out got %h expected %h", c, state_out, e[0].st); end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(s[2], k[2], rc[2], e[2]);
        send(s[3], k[3], rc[3], e[3]);
        wait_drain();
    endtask

    task automatic test_reset_midstream();
        logic [127:0] s;
        logic [127:0] k;
        exp_t         e;
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s = rand128(); k = rand128();
            send(s, k, 8'h04, model(s, k, 8'h04));
        end
        rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_empty !== 1'b1) begin errors++; $display("FAIL midreset_out_empty got %b expected 1", out_empty); end
        checks++; if (state_out !== '0)   begin errors++; $display("FAIL midreset_state_out got %h expected 0", state_out); end
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL midreset_in_ready got %b expected 1", in_ready); end
        @(posedge clk); #1;
        s = rand128(); k = rand128();
        e = model(s, k, 8'h08);
        send(s, k, 8'h08, e);
        @(negedge clk);
        checks++; if (out_empty !== 1'b1) begin errors++; $display("FAIL midreset_latency_early got %b expected 1", out_empty); end
        @(negedge clk);
        checks++; if (out_empty !== 1'b0) begin errors++; $display("FAIL midreset_latency_2 got %b expected 0", out_empty); end
        wait_drain();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        in_empty  = 1'b1;
        out_ready = 1'b1;
        state_in  = '0;
        key_in    = '0;
        rcon_in   = '0;
        build_sbox();
        @(posedge clk); #1;
        test_reset();
        test_round1();
        test_last_round();
        test_rcon_wrap();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
